// File: rtl/quad2steer.sv
// Quadrature A/B decoder: wrapping position, step strobes, step period, sticky error.
// Optional input glitch filter enabled by defining QUAD_FILTER_EN (uses FILT_CYCLES).
module quad2steer #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PER_W       = 16,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             Reset_I,
    input  logic             steerA,
    input  logic             steerB,
    input  logic             clr,
    output logic [CNT_W-1:0] pos,
    output logic             step_stb,
    output logic             step_dir,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             err
);

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned INIT_W      = 9;
`ifdef QUAD_FILTER_EN
    localparam int unsigned INIT_CYC    = SYNC_STAGES + FILT_CYCLES;
`else
    localparam int unsigned INIT_CYC    = SYNC_STAGES;
`endif
    localparam logic [PER_W-1:0] PER_MAX = '1;

    if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt
        $error("quad2steer: FILT_CYCLES must be within 1..255");
    end

    typedef enum logic {ST_INIT, ST_TRACK} state_t;

    state_t            r_state;
    logic [1:0]        r_sync_a;
    logic [1:0]        r_sync_b;
    logic [1:0]        r_prev_ab;
    logic [PER_W-1:0]  r_per_cnt;
    logic [INIT_W-1:0] r_init_cnt;
    logic              r_hist_vld;

    logic [1:0]        w_ab;
    logic [1:0]        w_idx_cur;
    logic [1:0]        w_idx_prev;
    logic [1:0]        w_delta;
    logic              w_fwd;
    logic              w_rev;
    logic              w_ill;

    // Two-flop synchronizers for the asynchronous phase inputs
    always_ff @(posedge CLK or negedge Reset_I) begin
        if (!Reset_I) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[0], steerA};
            r_sync_b <= {r_sync_b[0], steerB};
        end
    end

`ifdef QUAD_FILTER_EN
    localparam logic [7:0] FILT_LAST = 8'(FILT_CYCLES - 1);

    logic       r_acc_a;
    logic       r_acc_b;
    logic [7:0] r_fcnt_a;
    logic [7:0] r_fcnt_b;

    // A new level is accepted only after FILT_CYCLES consecutive differing samples
    always_ff @(posedge CLK or negedge Reset_I) begin
        if (!Reset_I) begin
            r_acc_a  <= 1'b0;
            r_acc_b  <= 1'b0;
            r_fcnt_a <= '0;
            r_fcnt_b <= '0;
        end else begin
            if (r_sync_a[1] == r_acc_a) begin
                r_fcnt_a <= '0;
            end else if (r_fcnt_a == FILT_LAST) begin
                r_acc_a  <= r_sync_a[1];
                r_fcnt_a <= '0;
            end else begin
                r_fcnt_a <= r_fcnt_a + 8'd1;
            end
            if (r_sync_b[1] == r_acc_b) begin
                r_fcnt_b <= '0;
            end else if (r_fcnt_b == FILT_LAST) begin
                r_acc_b  <= r_sync_b[1];
                r_fcnt_b <= '0;
            end else begin
                r_fcnt_b <= r_fcnt_b + 8'd1;
            end
        end
    end

    assign w_ab = {r_acc_a, r_acc_b};
`else
    assign w_ab = {r_sync_a[1], r_sync_b[1]};
`endif

    // Gray-to-binary phase index: forward steps increment it by one modulo 4
    assign w_idx_cur  = {w_ab[1], w_ab[1] ^ w_ab[0]};
    assign w_idx_prev = {r_prev_ab[1], r_prev_ab[1] ^ r_prev_ab[0]};
    assign w_delta    = w_idx_cur - w_idx_prev;
    assign w_fwd      = (w_delta == 2'd1);
    assign w_rev      = (w_delta == 2'd3);
    assign w_ill      = (w_delta == 2'd2);

    // INIT waits for the input pipeline to flush so prev_ab starts from the real pin state
    always_ff @(posedge CLK or negedge Reset_I) begin
        if (!Reset_I) begin
            r_state    <= ST_INIT;
            r_prev_ab  <= '0;
            r_per_cnt  <= '0;
            r_init_cnt <= '0;
            r_hist_vld <= 1'b0;
            pos        <= '0;
            step_stb   <= 1'b0;
            step_dir   <= 1'b0;
            period     <= '0;
            period_vld <= 1'b0;
            err        <= 1'b0;
        end else begin
            step_stb   <= 1'b0;
            period_vld <= 1'b0;
            if (r_per_cnt != PER_MAX) begin
                r_per_cnt <= r_per_cnt + PER_W'(1);
            end

            case (r_state)
                ST_INIT: begin
                    r_prev_ab <= w_ab;
                    if (r_init_cnt == INIT_W'(INIT_CYC)) begin
                        r_state <= ST_TRACK;
                    end else begin
                        r_init_cnt <= r_init_cnt + INIT_W'(1);
                    end
                end
                ST_TRACK: begin
                    r_prev_ab <= w_ab;
                    if (w_fwd || w_rev) begin
                        step_stb   <= 1'b1;
                        step_dir   <= w_fwd;
                        pos        <= w_fwd ? pos + CNT_W'(1) : pos - CNT_W'(1);
                        r_per_cnt  <= PER_W'(1);
                        r_hist_vld <= 1'b1;
                        if (r_hist_vld && (step_dir == w_fwd)) begin
                            period     <= r_per_cnt;
                            period_vld <= 1'b1;
                        end
                    end else if (w_ill) begin
                        err       <= 1'b1;
                        r_per_cnt <= PER_W'(1);
                    end
                end
                default: r_state <= ST_INIT;
            endcase

            // Clear overrides any same-cycle step bookkeeping except the strobe itself
            if (clr) begin
                pos        <= '0;
                err        <= 1'b0;
                r_per_cnt  <= '0;
                r_hist_vld <= 1'b0;
                period_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad2steer.sv
// Directed bench for quad2steer: steps, wrap, period, illegal moves, clear, reset.
module tb_quad2steer;

`ifdef QUAD_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic        CLK;
    logic        Reset_I;
    logic        steerA;
    logic        steerB;
    logic        clr;
    logic [7:0]  pos;
    logic        step_stb;
    logic        step_dir;
    logic [15:0] period;
    logic        period_vld;
    logic        err;

    int total = 0;
    int bad   = 0;
    int stb_cnt = 0;
    int snap;

    quad2steer #(.CNT_W(8), .PER_W(16), .FILT_CYCLES(4)) dut (
        .CLK        (CLK),
        .Reset_I    (Reset_I),
        .steerA     (steerA),
        .steerB     (steerB),
        .clr        (clr),
        .pos        (pos),
        .step_stb   (step_stb),
        .step_dir   (step_dir),
        .period     (period),
        .period_vld (period_vld),
        .err        (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) if (step_stb === 1'b1) stb_cnt <= stb_cnt + 1;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b);
        steerA = a;
        steerB = b;
    endtask

    // One step: edge, latency boundary check, outputs at the strobe, then pad to 10 cycles
    task automatic do_step(input string tag, input logic a, input logic b, input int exp_pos,
                           input logic exp_dir, input logic exp_vld, input int exp_per);
        drive(a, b);
        tick(LAT - 1);
        check({tag, "_early_stb"}, 32'(step_stb), 32'd0);
        tick(1);
        check({tag, "_stb"}, 32'(step_stb), 32'd1);
        check({tag, "_pos"}, 32'(pos), 32'(exp_pos));
        check({tag, "_dir"}, 32'(step_dir), 32'(exp_dir));
        check({tag, "_vld"}, 32'(period_vld), 32'(exp_vld));
        if (exp_vld) check({tag, "_period"}, 32'(period), 32'(exp_per));
        tick(10 - LAT);
    endtask

    initial begin
        Reset_I = 1'b0;
        clr     = 1'b0;
        drive(1'b0, 1'b0);
        tick(3);
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_stb", 32'(step_stb), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        Reset_I = 1'b1;
        tick(10);

        // forward sequence, 10 cycles apart
        do_step("f1", 1'b0, 1'b1, 1, 1'b1, 1'b0, 0);
        do_step("f2", 1'b1, 1'b1, 2, 1'b1, 1'b1, 10);
        do_step("f3", 1'b1, 1'b0, 3, 1'b1, 1'b1, 10);
        do_step("f4", 1'b0, 1'b0, 4, 1'b1, 1'b1, 10);
        check("f_stb_count", 32'(stb_cnt), 32'd4);

        // clear, reverse wrap below zero, then reversal back
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_pos", 32'(pos), 32'd0);
        tick(5);
        do_step("r1", 1'b1, 1'b0, 255, 1'b0, 1'b0, 0);
        do_step("r2", 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);

        // illegal double-bit change
        drive(1'b1, 1'b1);
        tick(LAT + 2);
        check("ill_err", 32'(err), 32'd1);
        check("ill_pos", 32'(pos), 32'd0);
        check("ill_stb_count", 32'(stb_cnt), 32'd6);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("ill_clr_err", 32'(err), 32'd0);
        check("ill_clr_pos", 32'(pos), 32'd0);
        tick(5);
        do_step("ill_next", 1'b1, 1'b0, 1, 1'b1, 1'b0, 0);

        // period saturation
        do_step("sat_a", 1'b0, 1'b0, 2, 1'b1, 1'b1, 10);
        tick(70000);
        do_step("sat_b", 1'b0, 1'b1, 3, 1'b1, 1'b1, 65535);

        // clear coincident with a legal step
        drive(1'b1, 1'b1);
        tick(LAT - 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("cc_stb", 32'(step_stb), 32'd1);
        check("cc_dir", 32'(step_dir), 32'd1);
        check("cc_pos", 32'(pos), 32'd0);
        check("cc_err", 32'(err), 32'd0);
        check("cc_vld", 32'(period_vld), 32'd0);
        tick(5);

        // reset while a step is in flight, A=B=1 through release
        drive(1'b1, 1'b0);
        tick(1);
        Reset_I = 1'b0;
        drive(1'b1, 1'b1);
        #1;
        check("mr_pos", 32'(pos), 32'd0);
        check("mr_stb", 32'(step_stb), 32'd0);
        check("mr_dir", 32'(step_dir), 32'd0);
        check("mr_period", 32'(period), 32'd0);
        check("mr_vld", 32'(period_vld), 32'd0);
        check("mr_err", 32'(err), 32'd0);
        snap = stb_cnt;
        tick(3);
        Reset_I = 1'b1;
        tick(12);
        check("mr_rel_pos", 32'(pos), 32'd0);
        check("mr_rel_err", 32'(err), 32'd0);
        check("mr_rel_stb_count", 32'(stb_cnt), 32'(snap));
        do_step("mr_next", 1'b1, 1'b0, 1, 1'b1, 1'b0, 0);

`ifdef QUAD_FILTER_EN
        // short glitch is rejected, a stable change is accepted after 7 cycles
        snap = stb_cnt;
        drive(1'b0, 1'b0);
        tick(2);
        drive(1'b1, 1'b0);
        tick(12);
        check("gl_stb_count", 32'(stb_cnt), 32'(snap));
        check("gl_pos", 32'(pos), 32'd1);
        drive(1'b0, 1'b0);
        tick(6);
        check("flt_early_stb", 32'(step_stb), 32'd0);
        tick(1);
        check("flt_stb", 32'(step_stb), 32'd1);
        check("flt_pos", 32'(pos), 32'd2);
        tick(5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
